vram_arbiter: RTL

Arbitrates a single-port synchronous frame-buffer RAM between the VGA scan-out reader and a draw-engine writer. Sits between the VGA controller (`row`, `col`, `rdn`, `pixel`) and the RAM, on the system clock that also feeds the pixel-clock divider. Scan-out reads have absolute priority, one per pixel period. Writes fill the remaining RAM cycles through a valid/ready handshake.

---
 rtl/vram_arbiter_pkg.sv | 18 +
 rtl/vram_arbiter_if.sv | 32 +++
 rtl/vram_arbiter_pix_addr.sv | 15 +
 rtl/vram_arbiter.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/vram_arbiter_pkg.sv
// Shared defaults, FSM state encoding and blanking value for the VGA frame-buffer arbiter.
package vram_pkg;

  localparam int H_RES_DEF  = 640;
  localparam int V_RES_DEF  = 480;
  localparam int ADDR_W_DEF = 19;
  localparam int DATA_W_DEF = 12;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_ISSUE = 2'd1,
    RD_WAIT  = 2'd2,
    WR       = 2'd3
  } vram_state_e;

  localparam logic [DATA_W_DEF-1:0] BLANK_PIXEL = 12'h000;

endpackage

// File: rtl/vram_arbiter_if.sv
// Bus bundle between the arbiter (slave) and its surroundings: VGA scan-out, draw-engine writer, RAM.
interface vram_arbiter_if #(
  parameter int ADDR_W = vram_pkg::ADDR_W_DEF,
  parameter int DATA_W = vram_pkg::DATA_W_DEF
);
  logic              pix_tick;
  logic [8:0]        row;
  logic [9:0]        col;
  logic              rdn;
  logic [DATA_W-1:0] pixel;
  logic              wr_valid;
  logic              wr_ready;
  logic [8:0]        wr_row;
  logic [9:0]        wr_col;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              underrun;
  logic              wr_drop;

  modport slave (
    input  pix_tick, row, col, rdn, wr_valid, wr_row, wr_col, wr_data, mem_rdata,
    output pixel, wr_ready, mem_addr, mem_we, mem_wdata, underrun, wr_drop
  );

  modport master (
    output pix_tick, row, col, rdn, wr_valid, wr_row, wr_col, wr_data, mem_rdata,
    input  pixel, wr_ready, mem_addr, mem_we, mem_wdata, underrun, wr_drop
  );
endinterface

// File: rtl/vram_arbiter_pix_addr.sv
// Linear frame-buffer address row*640 + col, built from two shifted copies of row (512 + 128).
module pix_addr #(
  parameter int ADDR_W = vram_pkg::ADDR_W_DEF
) (
  input  logic [8:0]        row_i,
  input  logic [9:0]        col_i,
  output logic [ADDR_W-1:0] addr_o
);

  // Shift-add address; no multiplier.
  always_comb begin
    addr_o = ADDR_W'({row_i, 9'd0}) + ADDR_W'({row_i, 7'd0}) + ADDR_W'(col_i);
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port frame-buffer arbiter: scan-out reads win every pixel period, writer fills the gaps.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int H_RES  = H_RES_DEF,
  parameter int V_RES  = V_RES_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input logic          clk,
  input logic          rst,
  vram_arbiter_if.slave bus
);

  vram_state_e       state_q, state_d;
  logic              rd_pend_q, rd_pend_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] pixel_q, pixel_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              underrun_q, underrun_d;
  logic              wr_drop_q, wr_drop_d;
  logic              run_q;

  logic [ADDR_W-1:0] rd_addr_s;
  logic [ADDR_W-1:0] wr_addr_s;
  logic              wr_in_range_s;
  logic              tick_ok_s;
  logic              wr_ready_s;

  pix_addr #(.ADDR_W(ADDR_W)) u_rd_addr (
    .row_i (bus.row),
    .col_i (bus.col),
    .addr_o(rd_addr_s)
  );

  pix_addr #(.ADDR_W(ADDR_W)) u_wr_addr (
    .row_i (bus.wr_row),
    .col_i (bus.wr_col),
    .addr_o(wr_addr_s)
  );

  // A tick is only taken when no read is pending or in flight; run_q keeps wr_ready low in reset.
  always_comb begin
    wr_in_range_s = (bus.wr_row < 9'(V_RES)) && (bus.wr_col < 10'(H_RES));
    tick_ok_s     = bus.pix_tick & ~rd_pend_q & ((state_q == IDLE) | (state_q == WR));
    wr_ready_s    = run_q & (state_q == IDLE) & ~rd_pend_q & ~bus.pix_tick;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      rd_pend_q   <= 1'b0;
      rd_addr_q   <= '0;
      pixel_q     <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      underrun_q  <= 1'b0;
      wr_drop_q   <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_pend_q   <= rd_pend_d;
      rd_addr_q   <= rd_addr_d;
      pixel_q     <= pixel_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      underrun_q  <= underrun_d;
      wr_drop_q   <= wr_drop_d;
      run_q       <= 1'b1;
    end
  end

  // Next-state: tick capture, read sequencing, single-cycle write slots.
  always_comb begin
    state_d     = state_q;
    rd_pend_d   = rd_pend_q;
    rd_addr_d   = rd_addr_q;
    pixel_d     = pixel_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    underrun_d  = underrun_q | (bus.pix_tick & ~tick_ok_s);
    wr_drop_d   = wr_drop_q;

    if (tick_ok_s) begin
      if (!bus.rdn) begin
        rd_pend_d = 1'b1;
        rd_addr_d = rd_addr_s;
      end else begin
        pixel_d = DATA_W'(BLANK_PIXEL);
      end
    end else begin
      rd_pend_d = rd_pend_d;
    end

    case (state_q)
      IDLE: begin
        if (rd_pend_q) begin
          state_d    = RD_ISSUE;
          mem_addr_d = rd_addr_q;
          rd_pend_d  = 1'b0;
        end else if (bus.wr_valid && wr_ready_s) begin
          // Out-of-range requests still complete the handshake but never reach the RAM.
          state_d     = WR;
          mem_addr_d  = wr_addr_s;
          mem_wdata_d = bus.wr_data;
          mem_we_d    = wr_in_range_s;
          wr_drop_d   = wr_drop_q | ~wr_in_range_s;
        end else begin
          state_d = IDLE;
        end
      end
      RD_ISSUE: begin
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        state_d = IDLE;
        pixel_d = bus.mem_rdata;
      end
      WR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.pixel     = pixel_q;
  assign bus.wr_ready  = wr_ready_s;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.underrun  = underrun_q;
  assign bus.wr_drop   = wr_drop_q;

endmodule
